seven_segment_mux: RTL and testbench
====================================

# seven_segment_mux

Time-multiplexed driver for a bank of common-anode/common-cathode seven-segment digits sharing one segment bus. It is the parametrised successor of our two-digit static hex display block, with configurable digit count, refresh rate, polarity, decimal points, leading-zero blanking and anti-ghosting dead time. A double-buffered value register prevents tearing within a frame. It sits between any debug/status register and the board display pins.

## Interface
- DIGITS, 4, number of digits, legal range 1..8
- REFRESH_DIV, 1000, clk cycles each digit is lit, at least 2
- DEAD_CYCLES, 4, all-anodes-off cycles between digits; 0 removes the dead phase
- SEG_ACTIVE_LOW, 1, 1 = segments and dp are driven low to light
- AN_ACTIVE_LOW, 1, 1 = anodes are driven low to enable
- BLANK_LEADING, 1, 1 = blank leading zero digits
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- data_in  in  4*DIGITS  hex value; nibble k drives digit k, with digit 0 as the LSD
- dp_in  in  DIGITS  decimal point per digit
- load  in  1  capture strobe for data_in/dp_in
- seg  out  7  segments; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
- dp  out  1  decimal point of the digit currently lit
- anode  out  DIGITS  digit enables, one-hot or all-off
- frame_done  out  1  one-cycle pulse after the last digit of each frame

## Operation
- Registers:
  - pending (data/dp) is written on every clk edge with load=1.
  - active (data/dp) is the displayed copy. It is updated from pending only at frame wrap.
- FSM:
  - SHOW: the digit at index idx is lit. The counter runs 0..REFRESH_DIV-1. At REFRESH_DIV-1 the FSM goes to DEAD, or directly advances idx when DEAD_CYCLES=0.
  - DEAD: all anodes are off. The counter runs 0..DEAD_CYCLES-1. At the last count, idx advances and the FSM returns to SHOW.
- Advancing idx:
  - idx wraps from DIGITS-1 to 0.
  - On wrap, active is loaded from pending and frame_done pulses.
- Load coinciding with wrap: active takes the pre-edge pending value, and the new data stays in pending for the next frame.
- Decode table (unlit-polarity-independent, 1 = lit): 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 b:1F C:4E d:3D E:4F F:47.
- Blanking (BLANK_LEADING=1): digit k>0 is blanked (seg all unlit) if nibbles DIGITS-1..k of active are all zero.
  - Digit 0 is never blanked.
  - dp ignores blanking.
- Polarity: the final seg/dp are inverted when SEG_ACTIVE_LOW; anode is inverted when AN_ACTIVE_LOW.
- Reset (asynchronous, immediate regardless of phase):
  - idx=0, state SHOW, counter 0.
  - pending=0, active=0.
  - anode all inactive, seg and dp unlit, frame_done=0.

## Timing
- All outputs are registered, with 1 cycle latency from FSM state to pins.
- First edge after rst deasserts: the FSM is in SHOW idx 0. anode[0] is active from the second edge.
- Each digit is lit for exactly REFRESH_DIV cycles, followed by DEAD_CYCLES all-off cycles.
- Frame period = DIGITS*(REFRESH_DIV+DEAD_CYCLES) cycles.
- anode never has more than one active bit. It is all-off for every DEAD cycle.
- frame_done is high for exactly 1 cycle per frame. It is aligned with the first output cycle of digit 0 in the new frame.
- Worst-case latency from load to display: one frame period plus 1 cycle.
- DIGITS=1: idx stays 0 and wraps on every advance; frame_done pulses once per REFRESH_DIV+DEAD_CYCLES cycles.

## Structure
- Package seven_segment_pkg contains:
  - the 16 segment localparams;
  - a function hex_to_seg(nibble) returning the active-high 7-bit pattern;
  - an FSM state enum {SHOW, DEAD}.
- One sub-module, seg_hex_decoder: combinational nibble to 7-bit active-high pattern. It is instantiated once, on the muxed nibble.
- Counter width is clog2(max(REFRESH_DIV, DEAD_CYCLES, 1)). idx width is clog2(DIGITS), minimum 1.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, active-low.
- Reset, then load data_in=16'h12AF, dp_in=4'b0100 -> after the next wrap, pin sequence per digit 0..3:
  - seg=~7'h47, dp=1;
  - seg=~7'h77, dp=1;
  - seg=~7'h6D, dp=0;
  - seg=~7'h30, dp=1.
  - Each digit lasts 4 cycles with anode=~(1<<k), separated by 1 cycle of anode=4'hF.
- Load 16'h0005 -> digits 1..3 show seg=7'h7F (blank) and digit 0 shows ~7'h5B. With BLANK_LEADING=0, digits 1..3 show ~7'h7E.
- Load 16'h0000 -> digit 0 shows ~7'h7E and digits 1..3 are blank.
- Load 16'h1111 mid-frame, then 16'h2222 on the wrap edge -> the next frame shows all 1s and the following frame shows all 2s. There is no mixed frame.
- Free run over 3 frames -> frame_done pulses every 20 cycles, exactly 1 cycle wide. anode is never multi-hot.
- Assert rst during SHOW idx 2 -> outputs go to anode=4'hF, seg=7'h7F, dp=1 without waiting for clk. After release, the display restarts at idx 0 showing 0.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the multiplexed seven-segment driver: glyph table,
// nibble decode helper and FSM state type.
package seven_segment_pkg;

  // Active-high segment patterns, bit6=a .. bit0=g
  localparam logic [6:0] SEG_HEX_0 = 7'h7E;
  localparam logic [6:0] SEG_HEX_1 = 7'h30;
  localparam logic [6:0] SEG_HEX_2 = 7'h6D;
  localparam logic [6:0] SEG_HEX_3 = 7'h79;
  localparam logic [6:0] SEG_HEX_4 = 7'h33;
  localparam logic [6:0] SEG_HEX_5 = 7'h5B;
  localparam logic [6:0] SEG_HEX_6 = 7'h5F;
  localparam logic [6:0] SEG_HEX_7 = 7'h70;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h7B;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h1F;
  localparam logic [6:0] SEG_HEX_C = 7'h4E;
  localparam logic [6:0] SEG_HEX_D = 7'h3D;
  localparam logic [6:0] SEG_HEX_E = 7'h4F;
  localparam logic [6:0] SEG_HEX_F = 7'h47;

  typedef enum logic {SHOW, DEAD} state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0:    return SEG_HEX_0;
      4'h1:    return SEG_HEX_1;
      4'h2:    return SEG_HEX_2;
      4'h3:    return SEG_HEX_3;
      4'h4:    return SEG_HEX_4;
      4'h5:    return SEG_HEX_5;
      4'h6:    return SEG_HEX_6;
      4'h7:    return SEG_HEX_7;
      4'h8:    return SEG_HEX_8;
      4'h9:    return SEG_HEX_9;
      4'hA:    return SEG_HEX_A;
      4'hB:    return SEG_HEX_B;
      4'hC:    return SEG_HEX_C;
      4'hD:    return SEG_HEX_D;
      4'hE:    return SEG_HEX_E;
      default: return SEG_HEX_F;
    endcase
  endfunction

endpackage

// File: rtl/seven_segment_mux_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg_hex_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = hex_to_seg(i_nibble);
  end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed seven-segment driver with double-buffered value, leading-zero
// blanking, configurable polarity and inter-digit dead time.
module seven_segment_mux
  import seven_segment_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int DEAD_CYCLES    = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV :
                           ((DEAD_CYCLES > 1) ? DEAD_CYCLES : 1);
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0]     RD_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]     DEAD_LAST = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{AN_ACTIVE_LOW != 0}};
  localparam logic [6:0]        SEG_OFF   = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic              DP_OFF    = (SEG_ACTIVE_LOW != 0);

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic                  r_run;
  logic                  r_wrap;
  logic [4*DIGITS-1:0]   r_pend_data;
  logic [DIGITS-1:0]     r_pend_dp;
  logic [4*DIGITS-1:0]   r_act_data;
  logic [DIGITS-1:0]     r_act_dp;

  logic [3:0]            w_nib;
  logic [6:0]            w_dec;
  logic [6:0]            w_seg_hi;
  logic                  w_blank;
  logic                  w_dp_lit;
  logic                  w_zero_run;
  logic                  w_advance;
  logic                  w_lit;
  logic [DIGITS-1:0]     w_onehot;

  // Walk from the MSD down so the all-zero run above each digit is known
  // when that digit is the selected one.
  always_comb begin
    w_nib      = '0;
    w_dp_lit   = 1'b0;
    w_blank    = 1'b0;
    w_zero_run = 1'b1;
    for (int unsigned j = DIGITS; j > 0; j--) begin
      w_zero_run = w_zero_run && (r_act_data[4*(j-1) +: 4] == 4'h0);
      if (IW'(j - 1) == r_idx) begin
        w_nib    = r_act_data[4*(j-1) +: 4];
        w_dp_lit = r_act_dp[j-1];
        w_blank  = (BLANK_LEADING != 0) && (j > 1) && w_zero_run;
      end
    end
  end

  seg_hex_decoder u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_dec)
  );

  always_comb begin
    w_seg_hi  = w_blank ? '0 : w_dec;
    w_onehot  = DIGITS'(1) << r_idx;
    w_lit     = r_run && (r_state == SHOW);
    w_advance = r_run &&
                (((r_state == SHOW) && (r_cnt == RD_LAST) && (DEAD_CYCLES == 0)) ||
                 ((r_state == DEAD) && (r_cnt == DEAD_LAST)));
  end

  // r_run holds the FSM for one cycle after reset so digit 0 reaches the
  // pins on the second edge; outputs always reflect the pre-edge state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SHOW;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_run       <= 1'b0;
      r_wrap      <= 1'b0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_act_data  <= '0;
      r_act_dp    <= '0;
      anode       <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= DP_OFF;
      frame_done  <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_wrap <= 1'b0;
      if (load) begin
        r_pend_data <= data_in;
        r_pend_dp   <= dp_in;
      end
      if (r_run) begin
        unique case (r_state)
          SHOW: begin
            if (r_cnt == RD_LAST) begin
              r_cnt <= '0;
              if (DEAD_CYCLES != 0) r_state <= DEAD;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          DEAD: begin
            if (r_cnt == DEAD_LAST) begin
              r_cnt   <= '0;
              r_state <= SHOW;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        endcase
      end
      if (w_advance) begin
        if (r_idx == IDX_LAST) begin
          r_idx      <= '0;
          r_act_data <= r_pend_data;
          r_act_dp   <= r_pend_dp;
          r_wrap     <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      anode      <= w_lit ? (w_onehot ^ AN_OFF) : AN_OFF;
      seg        <= w_lit ? (w_seg_hi ^ SEG_OFF) : SEG_OFF;
      dp         <= (w_lit && w_dp_lit) ^ DP_OFF;
      frame_done <= r_wrap;
    end
  end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Self-checking bench: directed loads plus random loads, compared each cycle
// against a time-position reference model of the multiplexed display.
module tb_seven_segment_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;

  logic [6:0]  seg, seg_nb;
  logic        dp, dp_nb, fd, fd_nb;
  logic [3:0]  anode, anode_nb;

  int errors = 0;
  int checks = 0;
  int t = 0;
  int last_fd = 0;

  logic [15:0] m_pend = '0, m_act = '0;
  logic [3:0]  m_pdp = '0, m_adp = '0;
  logic [6:0]  tbl [16];

  seven_segment_mux #(
    .DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .load(load),
    .seg(seg), .dp(dp), .anode(anode), .frame_done(fd)
  );

  seven_segment_mux #(
    .DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEADING(0)
  ) dut_nb (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .load(load),
    .seg(seg_nb), .dp(dp_nb), .anode(anode_nb), .frame_done(fd_nb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d: observed %h expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic step();
    int p, d, w;
    logic [3:0] e_an, nib;
    logic [6:0] e_seg, e_seg_nb, raw;
    logic e_dp, e_fd;
    @(posedge clk);
    t++;
    // Frame f>=1 starts showing at edge 2+20f; its value is latched one edge earlier.
    if (t >= 2 && (t - 2) % 20 == 19) begin
      m_act = m_pend;
      m_adp = m_pdp;
    end
    if (load) begin
      m_pend = data_in;
      m_pdp  = dp_in;
    end
    #1;
    e_an = 4'hF; e_seg = 7'h7F; e_seg_nb = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    if (t >= 2) begin
      p = (t - 2) % 20;
      d = p / 5;
      w = p % 5;
      e_fd = (p == 0) && (t >= 22);
      if (w < 4) begin
        nib      = m_act[4*d +: 4];
        raw      = tbl[nib];
        e_an     = ~(4'b0001 << d);
        e_seg_nb = ~raw;
        e_seg    = (d > 0 && (m_act >> (4*d)) == 16'h0) ? 7'h7F : ~raw;
        e_dp     = ~m_adp[d];
      end
    end
    chk("anode", anode, e_an);
    chk("seg", seg, e_seg);
    chk("dp", dp, e_dp);
    chk("frame_done", fd, e_fd);
    chk("seg_noblank", seg_nb, e_seg_nb);
    chk("anode_noblank", anode_nb, e_an);
    chk("anode_onehot", ($countones(~anode) <= 1), 1);
    if (fd === 1'b1) begin
      if (last_fd > 0) chk("frame_period", t - last_fd, 20);
      last_fd = t;
    end
  endtask

  task automatic run_to(input int tt);
    while (t < tt) step();
  endtask

  task automatic load_at(input int tt, input logic [15:0] val, input logic [3:0] dpv);
    run_to(tt - 1);
    data_in = val;
    dp_in   = dpv;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    last_fd = 0;
  endtask

  initial begin
    int base, tt;
    logic [15:0] rv;
    tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_anode", anode, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_frame_done", fd, 1'b0);
    release_rst();

    load_at(3, 16'h12AF, 4'b0100);
    run_to(45);
    load_at(50, 16'h0005, 4'b0000);
    run_to(85);
    load_at(90, 16'h0000, 4'b0000);
    run_to(125);
    load_at(130, 16'h1111, 4'b0000);
    load_at(141, 16'h2222, 4'b0000);
    run_to(185);

    for (int f = 0; f < 8; f++) begin
      base = t;
      tt = t + int'($urandom_range(1, 20));
      rv = 16'($urandom) >> (4 * $urandom_range(0, 3));
      load_at(tt, rv, 4'($urandom));
      run_to(base + 20);
    end
    run_to(t + 45);

    tt = t + 1;
    while ((tt - 2) % 20 != 11) tt++;
    run_to(tt);
    chk("pre_rst_anode", anode, 4'hB);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_anode", anode, 4'hF);
    chk("async_rst_seg", seg, 7'h7F);
    chk("async_rst_dp", dp, 1'b1);
    chk("async_rst_frame_done", fd, 1'b0);
    m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
    release_rst();
    run_to(45);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
